// File: rtl/mux_result_dispatch.sv
// Purpose: 1-to-4 result dispatcher; one held word is routed to the channel picked by S, with per-channel delivery counters.
// Latency: 1 cycle from input accept to DaljaValidN. Sustains one word per cycle when the destination is ready.
// Backpressure: HyrjaReady follows DaljaReady of the held destination, so a stalled channel stalls the input.
module mux_result_dispatch #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Hyrja,
    input  logic [1:0]       S,
    input  logic             HyrjaValid,
    output logic             HyrjaReady,
    output logic [WIDTH-1:0] Dalja0,
    output logic [WIDTH-1:0] Dalja1,
    output logic [WIDTH-1:0] Dalja2,
    output logic [WIDTH-1:0] Dalja3,
    output logic             DaljaValid0,
    output logic             DaljaValid1,
    output logic             DaljaValid2,
    output logic             DaljaValid3,
    input  logic             DaljaReady0,
    input  logic             DaljaReady1,
    input  logic             DaljaReady2,
    input  logic             DaljaReady3,
    output logic [7:0]       Numero0,
    output logic [7:0]       Numero1,
    output logic [7:0]       Numero2,
    output logic [7:0]       Numero3
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       dest_q, dest_d;
    logic [3:0][7:0]  numero_q, numero_d;

    logic [3:0] rdy_vec;
    logic [3:0] vld_vec;
    logic       sel_rdy;
    logic       busy;
    logic       in_hs;
    logic       out_hs;

    // Only the ready of the held destination matters; the other three are ignored.
    always_comb begin
        rdy_vec    = {DaljaReady3, DaljaReady2, DaljaReady1, DaljaReady0};
        busy       = (state_q == BUSY);
        sel_rdy    = rdy_vec[dest_q];
        out_hs     = busy & sel_rdy;
        HyrjaReady = ~Reset & (~busy | sel_rdy);
        in_hs      = HyrjaValid & HyrjaReady;
        vld_vec    = busy ? (4'b0001 << dest_q) : 4'b0000;
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dest_d   = dest_q;
        numero_d = numero_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d = BUSY;
                    data_d  = Hyrja;
                    dest_d  = S;
                end
            end
            BUSY: begin
                // Accepting while delivering reloads the register, so back-to-back streams never bubble.
                if (in_hs) begin
                    data_d = Hyrja;
                    dest_d = S;
                end else if (out_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (out_hs) begin
            numero_d[dest_q] = numero_q[dest_q] + 8'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            dest_q   <= 2'd0;
            numero_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dest_q   <= dest_d;
            numero_q <= numero_d;
        end
    end

    assign DaljaValid0 = vld_vec[0];
    assign DaljaValid1 = vld_vec[1];
    assign DaljaValid2 = vld_vec[2];
    assign DaljaValid3 = vld_vec[3];

    assign Dalja0 = vld_vec[0] ? data_q : '0;
    assign Dalja1 = vld_vec[1] ? data_q : '0;
    assign Dalja2 = vld_vec[2] ? data_q : '0;
    assign Dalja3 = vld_vec[3] ? data_q : '0;

    assign Numero0 = numero_q[0];
    assign Numero1 = numero_q[1];
    assign Numero2 = numero_q[2];
    assign Numero3 = numero_q[3];

endmodule

// File: tb/tb_mux_result_dispatch.sv
// Bench for mux_result_dispatch: directed vector table, streaming and wrap sequences, then a random scoreboard run.
module tb_mux_result_dispatch;

    logic        Clock;
    logic        Reset;
    logic [15:0] Hyrja;
    logic [1:0]  S;
    logic        HyrjaValid;
    logic        HyrjaReady;
    logic [15:0] d0, d1, d2, d3;
    logic        v0, v1, v2, v3;
    logic [3:0]  rdy;
    logic [7:0]  n0, n1, n2, n3;

    wire [3:0]  vld = {v3, v2, v1, v0};
    wire [31:0] num = {n3, n2, n1, n0};
    logic [15:0] dalja [4];
    assign dalja[0] = d0;
    assign dalja[1] = d1;
    assign dalja[2] = d2;
    assign dalja[3] = d3;

    mux_result_dispatch #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .Hyrja(Hyrja), .S(S),
        .HyrjaValid(HyrjaValid), .HyrjaReady(HyrjaReady),
        .Dalja0(d0), .Dalja1(d1), .Dalja2(d2), .Dalja3(d3),
        .DaljaValid0(v0), .DaljaValid1(v1), .DaljaValid2(v2), .DaljaValid3(v3),
        .DaljaReady0(rdy[0]), .DaljaReady1(rdy[1]), .DaljaReady2(rdy[2]), .DaljaReady3(rdy[3]),
        .Numero0(n0), .Numero1(n1), .Numero2(n2), .Numero3(n3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_hr, input logic [3:0] exp_vld,
                                 input logic [15:0] exp_dat, input logic [31:0] exp_num);
        chk({tag, " HyrjaReady"}, 128'(HyrjaReady), 128'(exp_hr));
        chk({tag, " valids"}, 128'(vld), 128'(exp_vld));
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s Dalja%0d", tag, i), 128'(dalja[i]), 128'(exp_vld[i] ? exp_dat : 16'h0000));
        chk({tag, " Numero"}, 128'(num), 128'(exp_num));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; HyrjaValid = 1'b0; rdy = 4'h0;
        tick();
        Reset = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        hv;
        logic [1:0]  s;
        logic [15:0] d;
        logic [3:0]  rdy;
        logic        exp_hr;
        logic [3:0]  exp_vld;
        logic [15:0] exp_dat;
        logic [31:0] exp_num;
    } vec_t;

    typedef struct {
        logic [1:0]  s;
        logic [15:0] d;
    } word_t;

    vec_t  tbl [15];
    word_t sb [$];
    int    cnt [4];

    initial begin
        // Inputs applied in a row are seen by the checks of that row; the clock edge follows.
        tbl[0]  = '{1'b1, 1'b1, 2'd2, 16'hA5A5, 4'hF, 1'b0, 4'h0, 16'h0000, 32'h0000_0000};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, 16'hA5A5, 4'h4, 1'b1, 4'h0, 16'h0000, 32'h0000_0000};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'h4, 1'b1, 4'h4, 16'hA5A5, 32'h0000_0000};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'h0, 1'b1, 4'h0, 16'h0000, 32'h0001_0000};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 16'h1234, 4'h0, 1'b1, 4'h0, 16'h0000, 32'h0001_0000};
        tbl[5]  = '{1'b0, 1'b1, 2'd0, 16'hFFFF, 4'hD, 1'b0, 4'h2, 16'h1234, 32'h0001_0000};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 16'h0000, 4'hD, 1'b0, 4'h2, 16'h1234, 32'h0001_0000};
        tbl[7]  = '{1'b0, 1'b1, 2'd3, 16'h5555, 4'hD, 1'b0, 4'h2, 16'h1234, 32'h0001_0000};
        tbl[8]  = '{1'b0, 1'b1, 2'd0, 16'hAAAA, 4'hD, 1'b0, 4'h2, 16'h1234, 32'h0001_0000};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 16'h0F0F, 4'hD, 1'b0, 4'h2, 16'h1234, 32'h0001_0000};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'h2, 1'b1, 4'h2, 16'h1234, 32'h0001_0000};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'h0, 16'h0000, 32'h0001_0100};
        tbl[12] = '{1'b0, 1'b1, 2'd0, 16'hFFFF, 4'h0, 1'b1, 4'h0, 16'h0000, 32'h0001_0100};
        tbl[13] = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'h1, 1'b0, 4'h1, 16'hFFFF, 32'h0001_0100};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'h0, 16'h0000, 32'h0000_0000};

        Reset = 1'b1; HyrjaValid = 1'b0; Hyrja = 16'h0; S = 2'd0; rdy = 4'h0;
        tick();
        tick();

        for (int i = 0; i < 15; i++) begin
            Reset = tbl[i].rst; HyrjaValid = tbl[i].hv; S = tbl[i].s;
            Hyrja = tbl[i].d; rdy = tbl[i].rdy;
            #1;
            check_outputs($sformatf("vec%0d", i), tbl[i].exp_hr, tbl[i].exp_vld,
                          tbl[i].exp_dat, tbl[i].exp_num);
            tick();
        end

        // Streaming: round-robin destinations with every channel ready, one word per cycle.
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int k = 0; k <= 8; k++) begin
            HyrjaValid = (k < 8); S = 2'(k % 4); Hyrja = 16'(16'h0100 + k); rdy = 4'hF;
            #1;
            if (k == 0)
                check_outputs("stream0", 1'b1, 4'h0, 16'h0000, 32'h0);
            else
                check_outputs($sformatf("stream%0d", k), 1'b1, 4'(4'b0001 << ((k - 1) % 4)),
                              16'(16'h0100 + k - 1),
                              {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])});
            if (k > 0) cnt[(k - 1) % 4]++;
            tick();
        end
        HyrjaValid = 1'b0;
        #1;
        check_outputs("stream_end", 1'b1, 4'h0, 16'h0000, 32'h0202_0202);
        tick();

        // Counter wrap: 256 deliveries to channel 3.
        do_reset();
        for (int k = 0; k <= 256; k++) begin
            HyrjaValid = (k < 256); S = 2'd3; Hyrja = 16'(k); rdy = 4'hF;
            if (k == 256) begin
                #1;
                check_outputs("wrap255", 1'b1, 4'h8, 16'h00FF, 32'hFF00_0000);
            end
            tick();
        end
        HyrjaValid = 1'b0;
        #1;
        check_outputs("wrap_end", 1'b1, 4'h0, 16'h0000, 32'h0000_0000);
        tick();

        // Random traffic against a queue scoreboard.
        do_reset();
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int k = 0; k < 10000; k++) begin
            logic        exp_hr;
            logic [3:0]  exp_vld;
            logic [15:0] exp_dat;
            logic [3:0]  r;
            HyrjaValid = ($urandom_range(0, 3) != 0);
            S = 2'($urandom_range(0, 3));
            Hyrja = 16'($urandom);
            r = 4'($urandom);
            rdy = r;
            #1;
            if (sb.size() == 0) begin
                exp_hr = 1'b1; exp_vld = 4'h0; exp_dat = 16'h0;
            end else begin
                exp_hr = r[sb[0].s]; exp_vld = 4'(4'b0001 << sb[0].s); exp_dat = sb[0].d;
            end
            chk($sformatf("rand%0d", k),
                {59'h0, HyrjaReady, vld, d3, d2, d1, d0},
                {59'h0, exp_hr, exp_vld,
                 exp_vld[3] ? exp_dat : 16'h0, exp_vld[2] ? exp_dat : 16'h0,
                 exp_vld[1] ? exp_dat : 16'h0, exp_vld[0] ? exp_dat : 16'h0});
            if (sb.size() != 0 && r[sb[0].s]) begin
                cnt[sb[0].s]++;
                void'(sb.pop_front());
            end
            if (HyrjaValid && exp_hr) sb.push_back('{S, Hyrja});
            tick();
            if (fails > 50) break;
        end
        HyrjaValid = 1'b0; rdy = 4'hF;
        #1;
        if (sb.size() != 0) begin
            cnt[sb[0].s]++;
            void'(sb.pop_front());
        end
        tick();
        #1;
        check_outputs("rand_end", 1'b1, 4'h0, 16'h0000,
                      {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])});

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
